// File: rtl/uart_pkg.sv
// Shared ASCII constants and parser state encoding for the UART receive path.
package uart_pkg;

  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_SP   = 8'h20;
  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_9    = 8'h39;
  localparam logic [7:0] CHAR_A_UP = 8'h41;
  localparam logic [7:0] CHAR_F_UP = 8'h46;
  localparam logic [7:0] CHAR_A_LO = 8'h61;
  localparam logic [7:0] CHAR_F_LO = 8'h66;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } parser_state_t;

endpackage

// File: rtl/ascii_hex_nibble.sv
// Combinational ASCII classifier: hex digit (either case) to nibble, plus
// CR/LF/space delimiter detection. Anything else reports neither class.
module ascii_hex_nibble
  import uart_pkg::*;
(
  input  logic [7:0] ascii,
  output logic       is_hex,
  output logic       is_delim,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ascii >= CHAR_0 && ascii <= CHAR_9) begin
      is_hex = 1'b1;
      nibble = 4'(ascii - CHAR_0);
    end else if (ascii >= CHAR_A_UP && ascii <= CHAR_F_UP) begin
      is_hex = 1'b1;
      nibble = 4'(ascii - CHAR_A_UP + 8'd10);
    end else if (ascii >= CHAR_A_LO && ascii <= CHAR_F_LO) begin
      is_hex = 1'b1;
      nibble = 4'(ascii - CHAR_A_LO + 8'd10);
    end
  end

  assign is_delim = (ascii == CHAR_CR) || (ascii == CHAR_LF) || (ascii == CHAR_SP);

endmodule

// File: rtl/ascii_hex_parser.sv
// Accumulates a stream of ASCII hex characters MSB-first into N_NIBBLES-digit
// words and presents each on a valid/ready output; bad tokens are drained.
//
// Output handshake: out_valid rises only in HOLD and stays high with out_word
// stable until a clock edge samples out_valid && out_ready; the word is then
// consumed and out_valid drops on the following cycle. rx_valid has no
// backpressure, so bytes that arrive while a word is pending are dropped.
module ascii_hex_parser
  import uart_pkg::*;
#(
  parameter int unsigned N_NIBBLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [4*N_NIBBLES-1:0]   out_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               digit_count,
  output logic                     err_pulse,
  output logic                     busy,
  output parser_state_t            state_dbg
);

  localparam int unsigned W = 4 * N_NIBBLES;
  localparam logic [3:0]  N_CNT = 4'(N_NIBBLES);

  parser_state_t state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  word_q, word_d;
  logic [3:0]    count_q, count_d;
  logic          err_q, err_d;

  logic          is_hex, is_delim;
  logic [3:0]    nib;
  logic [W+3:0]  shift_full;
  logic [W-1:0]  acc_shift;
  logic [3:0]    count_inc;

  ascii_hex_nibble u_nibble (
    .ascii    (rx_data),
    .is_hex   (is_hex),
    .is_delim (is_delim),
    .nibble   (nib)
  );

  // Dropping the top nibble keeps the newest N_NIBBLES digits right-aligned.
  assign shift_full = {acc_q, nib};
  assign acc_shift  = shift_full[W-1:0];
  assign count_inc  = count_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      word_q  <= '0;
      count_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    word_d  = word_q;
    count_d = count_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (is_hex) begin
            acc_d   = W'(nib);
            count_d = 4'd1;
            if (N_CNT == 4'd1) begin
              state_d = HOLD;
              word_d  = W'(nib);
            end else begin
              state_d = ACCUM;
            end
          end else if (!is_delim) begin
            err_d   = 1'b1;
            acc_d   = '0;
            count_d = 4'd0;
            state_d = DRAIN;
          end
        end
      end
      ACCUM: begin
        if (rx_valid) begin
          if (is_hex) begin
            acc_d   = acc_shift;
            count_d = count_inc;
            if (count_inc == N_CNT) begin
              state_d = HOLD;
              word_d  = acc_shift;
            end
          end else if (is_delim) begin
            state_d = HOLD;
            word_d  = acc_q;
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            count_d = 4'd0;
            state_d = DRAIN;
          end
        end
      end
      HOLD: begin
        // A byte landing here is lost; only non-delimiters count as overrun.
        if (rx_valid && !is_delim) begin
          err_d = 1'b1;
        end
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = 4'd0;
        end
      end
      DRAIN: begin
        if (rx_valid && is_delim) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_word    = word_q;
  assign out_valid   = (state_q == HOLD);
  assign digit_count = count_q;
  assign err_pulse   = err_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed bench for ascii_hex_parser: a table of per-byte vectors for the
// 2-digit build, plus hand sequences for async reset and a 4-digit build.
module tb_ascii_hex_parser;
  import uart_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [7:0]    out_word;
  logic          out_valid;
  logic [3:0]    digit_count;
  logic          err_pulse;
  logic          busy;
  parser_state_t state_dbg;

  logic [7:0]    n4_rx_data = 8'h00;
  logic          n4_rx_valid = 1'b0;
  logic          n4_out_ready = 1'b0;
  logic [15:0]   n4_out_word;
  logic          n4_out_valid;
  logic [3:0]    n4_digit_count;
  logic          n4_err_pulse;
  logic          n4_busy;
  parser_state_t n4_state_dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ascii_hex_parser #(.N_NIBBLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .digit_count (digit_count),
    .err_pulse   (err_pulse),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  ascii_hex_parser #(.N_NIBBLES(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (n4_rx_data),
    .rx_valid    (n4_rx_valid),
    .out_word    (n4_out_word),
    .out_valid   (n4_out_valid),
    .out_ready   (n4_out_ready),
    .digit_count (n4_digit_count),
    .err_pulse   (n4_err_pulse),
    .busy        (n4_busy),
    .state_dbg   (n4_state_dbg)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_word;
    logic       e_err;
    logic [3:0] e_cnt;
    logic       e_busy;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic [7:0] d, logic rdy, logic e_valid,
                              logic [7:0] e_word, logic e_err, logic [3:0] e_cnt,
                              logic e_busy);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.e_valid = e_valid; r.e_word = e_word;
    r.e_err = e_err; r.e_cnt = e_cnt; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    rx_valid  = v;
    rx_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic apply4(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    n4_rx_valid  = v;
    n4_rx_data   = d;
    n4_out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v, byte, ready | valid, word, err, count, busy  (checked after the edge)
    tbl[0]  = mk(1, "3",   1, 0, 8'h00, 0, 1, 1);
    tbl[1]  = mk(1, "F",   1, 1, 8'h3F, 0, 2, 1);
    tbl[2]  = mk(0, 8'h0,  1, 0, 8'h00, 0, 0, 0);
    tbl[3]  = mk(1, "a",   0, 0, 8'h00, 0, 1, 1);
    tbl[4]  = mk(1, 8'h0D, 0, 1, 8'h0A, 0, 1, 1);
    tbl[5]  = mk(0, 8'h0,  1, 0, 8'h00, 0, 0, 0);
    tbl[6]  = mk(1, "G",   1, 0, 8'h00, 1, 0, 1);
    tbl[7]  = mk(1, "1",   1, 0, 8'h00, 0, 0, 1);
    tbl[8]  = mk(1, "2",   1, 0, 8'h00, 0, 0, 1);
    tbl[9]  = mk(1, 8'h20, 1, 0, 8'h00, 0, 0, 0);
    tbl[10] = mk(1, "7",   1, 0, 8'h00, 0, 1, 1);
    tbl[11] = mk(1, "e",   1, 1, 8'h7E, 0, 2, 1);
    tbl[12] = mk(1, 8'h0A, 1, 0, 8'h00, 0, 0, 0);
    tbl[13] = mk(1, "C",   0, 0, 8'h00, 0, 1, 1);
    tbl[14] = mk(1, "3",   0, 1, 8'hC3, 0, 2, 1);
    tbl[15] = mk(1, "5",   0, 1, 8'hC3, 1, 2, 1);
    tbl[16] = mk(0, 8'h0,  0, 1, 8'hC3, 0, 2, 1);
    tbl[17] = mk(0, 8'h0,  1, 0, 8'h00, 0, 0, 0);
    tbl[18] = mk(0, 8'h0,  1, 0, 8'h00, 0, 0, 0);
    tbl[19] = mk(1, "4",   0, 0, 8'h00, 0, 1, 1);
    tbl[20] = mk(1, "z",   0, 0, 8'h00, 1, 0, 1);
    tbl[21] = mk(1, "x",   0, 0, 8'h00, 0, 0, 1);
    tbl[22] = mk(1, 8'h0D, 0, 0, 8'h00, 0, 0, 0);
    tbl[23] = mk(1, "b",   0, 0, 8'h00, 0, 1, 1);
    tbl[24] = mk(1, "9",   0, 1, 8'hB9, 0, 2, 1);
    tbl[25] = mk(1, "1",   1, 0, 8'h00, 1, 0, 0);
    tbl[26] = mk(1, "2",   0, 0, 8'h00, 0, 1, 1);
    tbl[27] = mk(1, 8'h0D, 0, 1, 8'h02, 0, 1, 1);
    tbl[28] = mk(1, 8'h0D, 1, 0, 8'h00, 0, 0, 0);
    tbl[29] = mk(1, "A",   0, 0, 8'h00, 0, 1, 1);
    tbl[30] = mk(1, "a",   1, 1, 8'hAA, 0, 2, 1);
    tbl[31] = mk(0, 8'h0,  1, 0, 8'h00, 0, 0, 0);
    tbl[32] = mk(1, 8'h20, 0, 0, 8'h00, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word",  32'(out_word), 32'd0);
    chk("rst_cnt",   32'(digit_count), 32'd0);
    chk("rst_err",   32'(err_pulse), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_word4", 32'(n4_out_word), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_err", i),   32'(err_pulse), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_cnt", i),   32'(digit_count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_busy", i),  32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_valid) chk($sformatf("v%0d_word", i), 32'(out_word), 32'(tbl[i].e_word));
    end

    // Asynchronous reset in the middle of a token, then a clean word.
    apply(1, "9", 0);
    chk("ar_pre_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_word",  32'(out_word), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_cnt",   32'(digit_count), 32'd0);
    chk("ar_busy",  32'(busy), 32'd0);
    chk("ar_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply(1, "D", 0);
    chk("ar_d_cnt", 32'(digit_count), 32'd1);
    apply(1, "4", 0);
    chk("ar_d4_valid", 32'(out_valid), 32'd1);
    chk("ar_d4_word",  32'(out_word), 32'hD4);
    apply(0, 8'h0, 1);
    chk("ar_d4_acc", 32'(out_valid), 32'd0);

    // Four-digit build.
    apply4(1, "B", 0);
    apply4(1, "E", 0);
    apply4(1, "E", 0);
    chk("n4_cnt3",  32'(n4_digit_count), 32'd3);
    chk("n4_pre_v", 32'(n4_out_valid), 32'd0);
    apply4(1, "F", 0);
    chk("n4_beef_valid", 32'(n4_out_valid), 32'd1);
    chk("n4_beef_word",  32'(n4_out_word), 32'hBEEF);
    chk("n4_beef_err",   32'(n4_err_pulse), 32'd0);
    apply4(0, 8'h0, 1);
    chk("n4_beef_acc", 32'(n4_out_valid), 32'd0);
    apply4(1, "1", 0);
    apply4(1, 8'h0D, 0);
    chk("n4_1_valid", 32'(n4_out_valid), 32'd1);
    chk("n4_1_word",  32'(n4_out_word), 32'h0001);
    chk("n4_1_cnt",   32'(n4_digit_count), 32'd1);
    apply4(0, 8'h0, 1);
    chk("n4_1_busy", 32'(n4_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
